// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address/data widths, fetch FSM states and the
// branch/jump target helper used by fetch and jump control.
package cpu_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // imm is two's complement at full address width, so a modulo-2^ADDR_W add
    // is exactly the sign-extended offset with wrap-around.
    function automatic logic [ADDR_W-1:0] calc_target(
        input logic              is_jump,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] imm
    );
        return is_jump ? imm : base + imm;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request bus between the fetch stage (master) and memory (slave).
// Handshake: req rises with addr and both hold steady until the single valid pulse
// (rdata qualified by valid) that answers it; that response cycle is not a new request.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input valid, input rdata);
    modport slave  (input req, input addr, output valid, output rdata);

endinterface

// File: rtl/fetch_target_calc.sv
// Combinational redirect target: absolute jump address or instr_pc-relative branch.
module fetch_target_calc
    import cpu_pkg::*;
(
    input  logic              is_jump,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] imm,
    output logic [ADDR_W-1:0] target
);

    assign target = calc_target(is_jump, base, imm);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, one-outstanding imem requests, registered instruction for decode.
// Build option FETCH_STATS_EN adds saturating fetch/redirect/drop counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 10'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetchCNTRL,
    input  logic              isJump,
    input  logic [ADDR_W-1:0] imm,
    input  logic              stall,
    fetch_unit_if.master      imem,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output fetch_state_t      state
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       redirect_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target;
    logic              req;
    logic              accept;

    fetch_target_calc u_target (
        .is_jump (isJump),
        .base    (instr_pc),
        .imm     (imm),
        .target  (target)
    );

    assign imem.req  = req;
    assign imem.addr = pc_q;
    assign state     = state_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                req = 1'b1;
                // A redirect wins over a word returning in the same cycle.
                if (fetchCNTRL) begin
                    state_d = imem.valid ? REQ : DROP;
                end else if (imem.valid) begin
                    accept  = 1'b1;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = stall ? HOLD : REQ;
                end
            end
            HOLD: begin
                if (fetchCNTRL || !stall) state_d = REQ;
            end
            DROP: begin
                if (imem.valid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (fetchCNTRL) pc_d = target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (fetchCNTRL) begin
                instr_valid <= 1'b0;
            end else if (accept) begin
                instr       <= imem.rdata;
                instr_pc    <= pc_q;
                instr_valid <= 1'b1;
            end else if (!stall) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic discard;

    assign discard = imem.valid &&
                     (((state_q == REQ) && fetchCNTRL) || (state_q == DROP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
            drop_cnt     <= '0;
        end else begin
            if (accept)     fetch_cnt    <= sat_inc(fetch_cnt);
            if (fetchCNTRL) redirect_cnt <= sat_inc(redirect_cnt);
            if (discard)    drop_cnt     <= sat_inc(drop_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model plus
// directed scenarios with hand-computed addresses and instruction words.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetchCNTRL = 1'b0;
    logic              isJump = 1'b0;
    logic              stall = 1'b0;
    logic [ADDR_W-1:0] imm = '0;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    fetch_state_t      dbg_state;

    fetch_unit_if imem ();

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt, redirect_cnt, drop_cnt;
`endif

    fetch_unit #(.RESET_PC(10'h000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetchCNTRL  (fetchCNTRL),
        .isJump      (isJump),
        .imm         (imm),
        .stall       (stall),
        .imem        (imem),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .state       (dbg_state)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .redirect_cnt (redirect_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a ^ 10'h2A5;
    endfunction

    // Instruction memory: accepts a request when idle, answers after lat cycles.
    int                lat = 1;
    logic              mem_busy = 1'b0;
    int                mem_cnt = 0;
    logic [ADDR_W-1:0] mem_addr = '0;

    initial begin
        imem.valid = 1'b0;
        imem.rdata = '0;
        forever begin
            @(posedge clk);
            if (imem.valid) begin
                mem_busy = 1'b0;
            end else if (mem_busy && mem_cnt > 0) begin
                mem_cnt--;
            end else if (!mem_busy && imem.req) begin
                mem_busy = 1'b1;
                mem_cnt  = lat - 1;
                mem_addr = imem.addr;
            end
            #1;
            imem.valid = mem_busy && (mem_cnt == 0);
            imem.rdata = imem.valid ? mem_word(mem_addr) : '0;
        end
    end

    // Reference model, updated from the inputs seen at each rising edge.
    logic [ADDR_W-1:0] m_pc = 10'h000;
    logic [DATA_W-1:0] m_instr = '0;
    logic [ADDR_W-1:0] m_ipc = '0;
    logic              m_valid = 1'b0;
    logic              m_started = 1'b0;
    logic              m_stale = 1'b0;
    logic              m_hold = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_pc = 10'h000; m_instr = '0; m_ipc = '0; m_valid = 1'b0;
                m_started = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
            end else begin
                logic req_now;
                int   off;
                req_now = m_started && !m_stale && !m_hold;
                off = imm[9] ? int'(imm) - 1024 : int'(imm);
                if (fetchCNTRL) begin
                    if (req_now && !imem.valid) m_stale = 1'b1;
                    else if (m_stale && imem.valid) m_stale = 1'b0;
                    m_pc    = isJump ? imm : 10'((int'(m_ipc) + off + 1024) % 1024);
                    m_valid = 1'b0;
                    m_hold  = 1'b0;
                end else if (imem.valid && m_stale) begin
                    m_stale = 1'b0;
                end else if (imem.valid && req_now) begin
                    m_instr = imem.rdata;
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = 10'((int'(m_pc) + 1) % 1024);
                    m_hold  = stall;
                end else if (!stall) begin
                    m_valid = 1'b0;
                    m_hold  = 1'b0;
                end
                m_started = 1'b1;
            end
        end
    end

    logic saw7 = 1'b0;

    initial begin
        forever begin
            logic exp_req;
            @(negedge clk);
            exp_req = m_started && !m_stale && !m_hold;
            check("imem_req", imem.req, exp_req);
            if (exp_req) check("imem_addr", imem.addr, m_pc);
            check("instr_valid", instr_valid, m_valid);
            check("instr", instr, m_instr);
            check("instr_pc", instr_pc, m_ipc);
            if (instr_valid) check("instr_vs_mem", instr, mem_word(instr_pc));
            if (instr_valid && instr_pc == 10'h007) saw7 = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic jmp, input logic [ADDR_W-1:0] value);
        fetchCNTRL = 1'b1;
        isJump     = jmp;
        imm        = value;
        tick();
        fetchCNTRL = 1'b0;
        isJump     = 1'b0;
        imm        = '0;
    endtask

    task automatic expect_next_req(input string name, input logic [ADDR_W-1:0] a);
        int n = 0;
        while (!imem.req && n < 20) begin
            tick();
            n++;
        end
        check({name, "_seen"}, imem.req, 1);
        if (imem.req) check(name, imem.addr, a);
    endtask

    task automatic wait_instr(input string name, input logic [ADDR_W-1:0] a);
        int n = 0;
        while (!(instr_valid && instr_pc == a) && n < 40) begin
            tick();
            n++;
        end
        check(name, instr_valid && (instr_pc == a), 1);
    endtask

    task automatic wait_accept(input string name, input logic any, input logic [ADDR_W-1:0] a);
        int n = 0;
        while (!(mem_busy && mem_cnt == lat - 1 && (any || mem_addr == a)) && n < 40) begin
            tick();
            n++;
        end
        check(name, mem_busy && (mem_cnt == lat - 1), 1);
    endtask

    logic [ADDR_W-1:0] acc_q[$];

    initial begin
        forever begin
            @(posedge clk);
            if (!mem_busy && imem.req && !imem.valid) acc_q.push_back(imem.addr);
        end
    end

    initial begin
        int n;
        // Reset values and sequential fetch with single-cycle memory.
        lat = 1;
        tick(); tick();
        check("rst_instr_valid", instr_valid, 0);
        check("rst_imem_req", imem.req, 0);
        check("rst_imem_addr", imem.addr, 10'h000);
        check("rst_instr", instr, 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        acc_q.delete();
        rst_n = 1'b1;
        repeat (12) tick();
        check("seq_count", acc_q.size() >= 4, 1);
        if (acc_q.size() >= 4) begin
            check("seq_addr0", acc_q[0], 10'h000);
            check("seq_addr1", acc_q[1], 10'h001);
            check("seq_addr2", acc_q[2], 10'h002);
            check("seq_addr3", acc_q[3], 10'h003);
        end

        // Stall while the word at 5 returns: three held cycles, then resume at 6.
        n = 0;
        while (!(imem.req && imem.addr == 10'h005) && n < 40) begin
            tick();
            n++;
        end
        stall = 1'b1;
        repeat (5) tick();
        check("stall_req", imem.req, 0);
        check("stall_instr_pc", instr_pc, 10'h005);
        check("stall_instr", instr, 10'h2A0);
        check("stall_valid", instr_valid, 1);
        stall = 1'b0;
        expect_next_req("stall_resume", 10'h006);
        repeat (3) tick();

        // Absolute jump.
        redirect(1'b1, 10'h200);
        check("jump_flush", instr_valid, 0);
        expect_next_req("jump_addr", 10'h200);

        // Backward branch and wrapping forward branch.
        redirect(1'b1, 10'h010);
        wait_instr("reach_010", 10'h010);
        redirect(1'b0, 10'h3FC);
        check("branch_flush", instr_valid, 0);
        expect_next_req("branch_back", 10'h00C);
        redirect(1'b1, 10'h3FE);
        wait_instr("reach_3fe", 10'h3FE);
        redirect(1'b0, 10'h003);
        expect_next_req("branch_wrap", 10'h001);

        // Sequential PC wrap from 3FF to 000.
        redirect(1'b1, 10'h3FF);
        wait_instr("reach_3ff", 10'h3FF);
        expect_next_req("pc_wrap", 10'h000);

        // Redirect out of a stall hold takes priority over stall.
        stall = 1'b1;
        repeat (4) tick();
        check("hold_req", imem.req, 0);
        redirect(1'b1, 10'h123);
        expect_next_req("hold_redirect", 10'h123);
        stall = 1'b0;
        repeat (4) tick();

        // Redirect with a 3-cycle request to 007 outstanding: its data is dropped.
        lat = 3;
        redirect(1'b1, 10'h007);
        saw7 = 1'b0;
        wait_accept("accept_007", 1'b0, 10'h007);
        redirect(1'b1, 10'h040);
        check("drop_flush", instr_valid, 0);
        check("drop_state", int'(dbg_state), int'(DROP));
        expect_next_req("drop_addr", 10'h040);
        wait_instr("reach_040", 10'h040);
        check("drop_no_stale", saw7, 0);

        // Reset mid-request; the late response lands while idle and is ignored.
        wait_accept("accept_before_rst", 1'b1, '0);
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_instr_valid", instr_valid, 0);
        check("rst2_instr", instr, 0);
        check("rst2_instr_pc", instr_pc, 0);
        check("rst2_imem_req", imem.req, 0);
        expect_next_req("restart", 10'h000);
        wait_instr("restart_word", 10'h000);
        check("restart_instr", instr, 10'h2A5);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
